// File: rtl/ser_dser_loop.sv
// rtl/ser_dser_loop.sv - byte serializer/deserializer loopback over an internal 1-bit line
// A free-running 10-bit framer drives sline_q; a three-state receiver recovers the word.
module ser_dser_loop (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] in,
   output logic [7:0] out
);
   typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_STOP} rx_state_t;

   logic [3:0] tx_cnt_q, tx_cnt_d;
   logic [7:0] tx_sr_q, tx_sr_d;
   logic       sline_q, sline_d;
   rx_state_t  rx_state_q, rx_state_d;
   logic [7:0] rx_sr_q, rx_sr_d;
   logic [2:0] rx_cnt_q, rx_cnt_d;
   logic [7:0] out_q, out_d;
   logic [2:0] tx_idx;

   // tx_cnt 1..8 selects data bit 0..7; the 3-bit subtract maps 8 onto 7.
   assign tx_idx = tx_cnt_q[2:0] - 3'd1;

   always_comb begin
      tx_sr_d  = tx_sr_q;
      sline_d  = sline_q;
      tx_cnt_d = (tx_cnt_q == 4'd9) ? 4'd0 : tx_cnt_q + 4'd1;
      if (tx_cnt_q == 4'd0) begin
         tx_sr_d = in;
         sline_d = 1'b0;
      end else if (tx_cnt_q == 4'd9) begin
         sline_d = 1'b1;
      end else begin
         sline_d = tx_sr_q[tx_idx];
      end
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_sr_d    = rx_sr_q;
      rx_cnt_d   = rx_cnt_q;
      out_d      = out_q;
      case (rx_state_q)
         RX_IDLE: begin
            if (!sline_q) begin
               rx_state_d = RX_DATA;
               rx_cnt_d   = 3'd0;
            end
         end
         RX_DATA: begin
            rx_sr_d  = {sline_q, rx_sr_q[7:1]};
            rx_cnt_d = rx_cnt_q + 3'd1;
            if (rx_cnt_q == 3'd7) rx_state_d = RX_STOP;
         end
         RX_STOP: begin
            // A low stop bit is a framing error: the word is dropped.
            if (sline_q) out_d = rx_sr_q;
            rx_state_d = RX_IDLE;
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_cnt_q   <= 4'd0;
         tx_sr_q    <= 8'h00;
         sline_q    <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_sr_q    <= 8'h00;
         rx_cnt_q   <= 3'd0;
         out_q      <= 8'h00;
      end else begin
         tx_cnt_q   <= tx_cnt_d;
         tx_sr_q    <= tx_sr_d;
         sline_q    <= sline_d;
         rx_state_q <= rx_state_d;
         rx_sr_q    <= rx_sr_d;
         rx_cnt_q   <= rx_cnt_d;
         out_q      <= out_d;
      end
   end

   assign out = out_q;
endmodule

// File: tb/tb_ser_dser_loop.sv
// tb/tb_ser_dser_loop.sv - directed and random loopback checks against a frame-level model
// The model tracks which word each frame carries and what the line shows at each edge.
module tb_ser_dser_loop;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] in = 8'h00;
   logic [7:0] out;

   int checks = 0;
   int errors = 0;

   int         edge_n = 0;
   logic [7:0] cur_word = 8'h00;
   logic [7:0] exp_out = 8'h00;
   logic       exp_sline = 1'b1;

   ser_dser_loop dut (
      .clk   (clk),
      .reset (reset),
      .in    (in),
      .out   (out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s edge=%0d observed=%h expected=%h", tag, edge_n, obs, exp);
      end
   endtask

   // One clock edge with the given inputs; the model advances by frame position.
   task automatic do_edge(input logic [7:0] din, input logic rst);
      int pos;
      in    = din;
      reset = rst;
      @(posedge clk);
      #1;
      if (rst) begin
         edge_n    = 0;
         exp_out   = 8'h00;
         exp_sline = 1'b1;
      end else begin
         pos = edge_n % 10;
         if (pos == 0) begin
            if (edge_n >= 10) exp_out = cur_word;
            cur_word = din;
         end
         if (pos == 0)      exp_sline = 1'b0;
         else if (pos == 9) exp_sline = 1'b1;
         else               exp_sline = cur_word[pos-1];
         edge_n++;
      end
      chk("out", out, exp_out);
      chk("sline", {7'b0, dut.sline_q}, {7'b0, exp_sline});
   endtask

   task automatic hold(input logic [7:0] din, input int n);
      for (int i = 0; i < n; i++) do_edge(din, 1'b0);
   endtask

   task automatic do_reset(input logic [7:0] din, input int n);
      for (int i = 0; i < n; i++) do_edge(din, 1'b1);
   endtask

   logic [7:0] words [4];

   initial begin
      // Reset with A5 presented, then a single word.
      do_reset(8'hA5, 3);
      hold(8'hA5, 10);
      chk("single_pre", out, 8'h00);
      hold(8'hA5, 1);
      chk("single_A5", out, 8'hA5);

      // Back-to-back stream.
      do_reset(8'h00, 1);
      words[0] = 8'h3C; words[1] = 8'h00; words[2] = 8'hFF; words[3] = 8'h81;
      for (int w = 0; w < 4; w++) hold(words[w], 10);
      hold(8'h5A, 1);
      chk("stream_last", out, 8'h81);

      // Input change mid-frame affects only the next frame.
      do_reset(8'h00, 1);
      hold(8'h55, 4);
      hold(8'hAA, 7);
      chk("mid_55", out, 8'h55);
      hold(8'hAA, 10);
      chk("mid_AA", out, 8'hAA);

      // Reset in the middle of a frame.
      do_reset(8'h00, 1);
      hold(8'hC3, 5);
      do_reset(8'hC3, 2);
      chk("rst_mid", out, 8'h00);
      hold(8'h0F, 10);
      chk("rst_pre", out, 8'h00);
      hold(8'h0F, 1);
      chk("rst_0F", out, 8'h0F);

      // Line sequence for 8'h01 is 0,1,0,0,0,0,0,0,0,1 (checked per edge by the model).
      do_reset(8'h00, 1);
      hold(8'h01, 10);

      // Random per-edge input, including changes inside frames.
      do_reset(8'h00, 1);
      for (int i = 0; i < 400; i++) do_edge(8'($urandom_range(0, 255)), 1'b0);

      // Random reset pulses interleaved with random traffic.
      for (int r = 0; r < 5; r++) begin
         do_reset(8'($urandom_range(0, 255)), $urandom_range(1, 3));
         for (int i = 0; i < $urandom_range(5, 40); i++)
            do_edge(8'($urandom_range(0, 255)), 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ser_dser_loop.md
# ser_dser_loop

Byte-wide serializer/deserializer loopback block. It samples an 8-bit parallel word, frames it onto an internal 1-bit serial line, then recovers the word with a receiver and presents it on a parallel output. It is used as a self-contained SerDes datapath for serial-link bring-up and for file-driven simulation benches.

## Interface
- No parameters. Data width is fixed at 8; frame length is fixed at 10 bits: 1 start, 8 data, 1 stop.
- One clock; reset is synchronous and active-high.
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in  input  8  parallel word to transmit; sampled only on frame-load edges.
- out  output  8  last correctly received word, registered.

## Operation
- Internal serial line `sline` is a register, idle level 1.
- Transmitter uses a frame counter `tx_cnt` (0..9) that wraps, so the transmitter runs continuously with no idle gap between frames.
  - tx_cnt=0 (load): capture `in` into the TX shift register; `sline<=0` (start bit).
  - tx_cnt=1..8: `sline<=` data bit tx_cnt-1, LSB first.
  - tx_cnt=9: `sline<=1` (stop bit).
- Receiver is a state machine with states IDLE, DATA and STOP.
  - IDLE: if `sline==0`, go to DATA with the bit count cleared; otherwise stay in IDLE.
  - DATA: shift `sline` into the RX shift register, LSB first (shift right, new bit enters at bit 7). After 8 bits, go to STOP.
  - STOP: if `sline==1`, update `out` with the RX shift register. If `sline==0` (framing error), discard the word and hold `out`. Either way, return to IDLE.
- `in` changes between load edges have no effect on the frame in flight.
- Arithmetic: counters are unsigned and wrap-free within their ranges. There is no data transformation, so `out` equals the loaded `in` bit-for-bit.

## Timing
- Reset, while asserted at an edge:
  - `out=8'h00`, `sline=1`, `tx_cnt=0`.
  - RX goes to IDLE, and the RX shift register and bit count are cleared.
- Edge numbering: the first rising edge with reset=0 is edge 0.
  - Edge 0 loads `in` and drives the start bit.
  - Edges 1-8 drive d0..d7.
  - Edge 9 drives the stop bit.
  - Edge 10 starts the next frame.
- Receiver timing against the same numbering:
  - Edge 1: RX sees the start bit.
  - Edges 2-9: RX samples d0..d7.
  - Edge 10: RX checks the stop bit and `out` updates.
- Latency: a word loaded at edge 10k appears on `out` at edge 10k+10.
- Throughput: one word per 10 cycles. Back-to-back frames are required to be received; RX returns to IDLE in time to detect the next start bit at edge 10k+11.
- Reset mid-frame:
  - The partial frame is discarded and `out` returns to 0.
  - Framing restarts with a fresh load on the first edge after reset deasserts.
- `out` holds its value between updates, and updates exactly once per frame.

## Test plan
- Reset behaviour: assert reset for 3 cycles with in=8'hA5 -> `out==8'h00` and `sline==1` throughout reset.
- Single word: release reset with in=8'hA5 held -> `out` stays 8'h00 through edge 9; `out==8'hA5` after edge 10.
- Stream: present 8'h3C, 8'h00, 8'hFF, 8'h81 at edges 0, 10, 20, 30 -> `out` takes these same values after edges 10, 20, 30 and 40.
- Mid-frame input change: load 8'h55 at edge 0, change in to 8'hAA at edge 4 -> `out==8'h55` after edge 10 and `out==8'hAA` after edge 20.
- Reset mid-frame: load 8'hC3, assert reset at edge 5, release, load 8'h0F -> `out` is 8'h00 during and after reset, never shows 8'hC3, and shows 8'h0F 10 edges after release.
- Line check: probe `sline` for in=8'h01 -> the 10-bit sequence is 0,1,0,0,0,0,0,0,0,1.
